// File: rtl/psum_wb_seq_pkg.sv
// Shared definitions for the partial-sum writeback sequencer: state encoding
// and default geometry.
package psum_wb_seq_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int ADDR_BW_DEF = 11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    PT,
    FIN
  } state_e;

endpackage

// File: rtl/psum_wb_seq_sfp.sv
// Per-column special-function unit: modular accumulate of the stored partial
// sum with the new one, followed by an optional ReLU clamp.
module psum_wb_seq_sfp
  import psum_wb_seq_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEF
) (
  input  logic [psum_bw-1:0] q_i,
  input  logic [psum_bw-1:0] hold_i,
  input  logic               accum_i,
  input  logic               relu_i,
  input  logic               passthrough_i,
  output logic [psum_bw-1:0] out_o
);

  logic [psum_bw-1:0] sum;

  // Two's-complement add wraps modulo 2^psum_bw; the MSB is the sign.
  always_comb begin
    sum = accum_i ? (q_i + hold_i) : hold_i;
    if (passthrough_i) begin
      out_o = hold_i;
    end else if (relu_i && sum[psum_bw-1]) begin
      out_o = '0;
    end else begin
      out_o = sum;
    end
  end

endmodule

// File: rtl/psum_wb_seq.sv
// Writes output-FIFO words into PSUM SRAM, either accumulating onto the stored
// value (read, then write) or passing them straight through at one word/cycle.
module psum_wb_seq
  import psum_wb_seq_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int addr_bw = ADDR_BW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       len,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic                     accum,
  input  logic                     relu,
  output logic                     busy,
  output logic                     done,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_a,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q
);

  localparam logic [addr_bw-1:0] CNT_ONE = addr_bw'(1);

  state_e                   state_q, state_d;
  logic [addr_bw-1:0]       cnt_q, cnt_d;
  logic [addr_bw-1:0]       len_q, len_d;
  logic [addr_bw-1:0]       base_q, base_d;
  logic                     accum_q, accum_d;
  logic                     relu_q, relu_d;
  logic [col*psum_bw-1:0]   hold_q, hold_d;

  logic [addr_bw-1:0]       cur_addr;
  logic [addr_bw-1:0]       cnt_inc;
  logic [col*psum_bw-1:0]   rmw_data;

  assign cur_addr = base_q + cnt_q;
  assign cnt_inc  = cnt_q + CNT_ONE;

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_col
      psum_wb_seq_sfp #(
        .psum_bw(psum_bw)
      ) u_sfp (
        .q_i           (sram_q[gi*psum_bw +: psum_bw]),
        .hold_i        (hold_q[gi*psum_bw +: psum_bw]),
        .accum_i       (accum_q),
        .relu_i        (relu_q),
        .passthrough_i (1'b0),
        .out_o         (rmw_data[gi*psum_bw +: psum_bw])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      accum_q <= 1'b0;
      relu_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      accum_q <= accum_d;
      relu_q  <= relu_d;
      hold_q  <= hold_d;
    end
  end

  // Outputs decode from the registered state, so an async reset releases the
  // SRAM bus in the same instant it clears state_q.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    base_d   = base_q;
    accum_d  = accum_q;
    relu_d   = relu_q;
    hold_d   = hold_q;
    busy     = 1'b1;
    done     = 1'b0;
    ofifo_rd = 1'b0;
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (len == '0) begin
            state_d = FIN;
          end else begin
            len_d   = len;
            base_d  = base_addr;
            accum_d = accum;
            relu_d  = relu;
            cnt_d   = '0;
            state_d = accum ? RD : PT;
          end
        end
      end
      RD: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          sram_cen = 1'b0;
          sram_a   = cur_addr;
          hold_d   = ofifo_out;
          state_d  = WR;
        end
      end
      WR: begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
        sram_a   = cur_addr;
        sram_d   = rmw_data;
        cnt_d    = cnt_inc;
        state_d  = (cnt_inc == len_q) ? FIN : RD;
      end
      PT: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          sram_cen = 1'b0;
          sram_wen = 1'b0;
          sram_a   = cur_addr;
          sram_d   = ofifo_out;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_psum_wb_seq.sv
// Directed bench for psum_wb_seq with a behavioural SRAM and output FIFO.
module tb_psum_wb_seq;

  logic         clk;
  logic         reset;
  logic         start;
  logic [10:0]  len;
  logic [10:0]  base_addr;
  logic         accum;
  logic         relu;
  logic         busy;
  logic         done;
  logic         ofifo_valid;
  logic         ofifo_rd;
  logic [127:0] ofifo_out;
  logic         sram_cen;
  logic         sram_wen;
  logic [10:0]  sram_a;
  logic [127:0] sram_d;
  logic [127:0] sram_q;

  psum_wb_seq dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
    .accum(accum), .relu(relu), .busy(busy), .done(done),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_out(ofifo_out),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  // SRAM model, FIFO model and activity counters
  logic [127:0] mem [0:2047];
  logic [127:0] fifo_mem [0:31];
  int  rd_ptr = 0;
  int  wr_ptr = 0;
  logic stall = 1'b0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  int  pop_cnt = 0;
  int  viol = 0;
  logic [10:0] wr_log [0:63];
  int  wr_cyc [0:63];

  assign ofifo_valid = (rd_ptr != wr_ptr) && !stall;
  assign ofifo_out   = fifo_mem[rd_ptr % 32];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ofifo_rd && !ofifo_valid) viol = viol + 1;
    if (!sram_wen && sram_cen) viol = viol + 1;
    if (!sram_cen) begin
      if (!sram_wen) begin
        mem[sram_a] = sram_d;
        wr_log[wr_cnt % 64] = sram_a;
        wr_cyc[wr_cnt % 64] = cyc;
        wr_cnt = wr_cnt + 1;
      end else begin
        sram_q <= mem[sram_a];
        rd_cnt = rd_cnt + 1;
      end
    end
    if (ofifo_rd && ofifo_valid) begin
      rd_ptr <= rd_ptr + 1;
      pop_cnt = pop_cnt + 1;
    end
  end

  function automatic logic [127:0] fill(input logic [15:0] v);
    fill = {8{v}};
  endfunction

  task automatic push(input logic [127:0] w);
    fifo_mem[wr_ptr % 32] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic launch(input logic [10:0] l, input logic [10:0] b, input logic a, input logic r);
    @(negedge clk);
    len = l; base_addr = b; accum = a; relu = r; start = 1'b1;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        dcyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if ({sram_cen, sram_wen, ofifo_rd} !== 3'b110) begin n_err++; $display("FAIL reset_ctl: got cen/wen/rd=%b required 110", {sram_cen, sram_wen, ofifo_rd}); end
    n_checks++; if (sram_a !== 11'd0 || sram_d !== 128'd0) begin n_err++; $display("FAIL reset_bus: got a=%0d d=%h required 0/0", sram_a, sram_d); end
    reset = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_accum(input logic r);
    int dcyc;
    int w0;
    logic [127:0] exp6;
    mem[5] = fill(16'd3);
    mem[6] = fill(16'd2);
    push(fill(16'd4));
    push(fill(16'hFFF9));
    w0 = wr_cnt;
    launch(11'd2, 11'd5, 1'b1, r);
    wait_done(dcyc);
    exp6 = r ? 128'd0 : fill(16'hFFFB);
    $display("accum run relu=%0d done_cyc=%0d sram5=%h sram6=%h", r, dcyc, mem[5], mem[6]);
    n_checks++; if (dcyc !== 5) begin n_err++; $display("FAIL accum_latency relu=%0d: got %0d required 5", r, dcyc); end
    n_checks++; if (mem[5] !== fill(16'd7)) begin n_err++; $display("FAIL accum_word0 relu=%0d: got %h required %h", r, mem[5], fill(16'd7)); end
    n_checks++; if (mem[6] !== exp6) begin n_err++; $display("FAIL accum_word1 relu=%0d: got %h required %h", r, mem[6], exp6); end
    n_checks++; if (wr_cnt - w0 !== 2) begin n_err++; $display("FAIL accum_writes relu=%0d: got %0d required 2", r, wr_cnt - w0); end
    @(negedge clk);
    n_checks++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL accum_done_pulse relu=%0d: got done/busy=%b required 00", r, {done, busy}); end
  endtask

  task automatic test_passthrough;
    int dcyc;
    int w0;
    for (int k = 0; k < 3; k++) begin
      mem[20 + k] = fill(16'h1234);
      push(fill(16'h8001));
    end
    w0 = wr_cnt;
    launch(11'd3, 11'd20, 1'b0, 1'b1);
    wait_done(dcyc);
    $display("passthrough run done_cyc=%0d writes=%0d", dcyc, wr_cnt - w0);
    n_checks++; if (dcyc !== 4) begin n_err++; $display("FAIL pt_latency: got %0d required 4", dcyc); end
    n_checks++; if (wr_cnt - w0 !== 3) begin n_err++; $display("FAIL pt_writes: got %0d required 3", wr_cnt - w0); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (mem[20 + k] !== fill(16'h8001)) begin n_err++; $display("FAIL pt_data%0d: got %h required %h", k, mem[20 + k], fill(16'h8001)); end
    end
    n_checks++; if (wr_cyc[(w0 + 1) % 64] - wr_cyc[w0 % 64] !== 1 || wr_cyc[(w0 + 2) % 64] - wr_cyc[w0 % 64] !== 2)
      begin n_err++; $display("FAIL pt_consecutive: got gaps %0d,%0d required 1,2", wr_cyc[(w0 + 1) % 64] - wr_cyc[w0 % 64], wr_cyc[(w0 + 2) % 64] - wr_cyc[w0 % 64]); end
  endtask

  task automatic test_stall;
    int dcyc;
    int r0;
    int p0;
    mem[5] = fill(16'd3);
    mem[6] = fill(16'd2);
    push(fill(16'd4));
    push(fill(16'hFFF9));
    stall = 1'b1;
    launch(11'd2, 11'd5, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    r0 = rd_cnt; p0 = pop_cnt;
    repeat (4) @(negedge clk);
    n_checks++; if (rd_cnt - r0 !== 0 || pop_cnt - p0 !== 0) begin n_err++; $display("FAIL stall_quiet: got reads=%0d pops=%0d required 0/0", rd_cnt - r0, pop_cnt - p0); end
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b required 1", busy); end
    stall = 1'b0;
    wait_done(dcyc);
    $display("stall run done_cyc=%0d after release", dcyc);
    n_checks++; if (dcyc !== 4) begin n_err++; $display("FAIL stall_latency: got %0d required 4", dcyc); end
    n_checks++; if (mem[5] !== fill(16'd7) || mem[6] !== fill(16'hFFFB)) begin n_err++; $display("FAIL stall_data: got %h/%h required %h/%h", mem[5], mem[6], fill(16'd7), fill(16'hFFFB)); end
  endtask

  task automatic test_wrap;
    int dcyc;
    int w0;
    mem[2047] = fill(16'd1);
    mem[0] = fill(16'd10);
    push(fill(16'd1));
    push(fill(16'd1));
    w0 = wr_cnt;
    launch(11'd2, 11'd2047, 1'b1, 1'b0);
    wait_done(dcyc);
    $display("wrap run done_cyc=%0d addrs=%0d,%0d", dcyc, wr_log[w0 % 64], wr_log[(w0 + 1) % 64]);
    n_checks++; if (wr_log[w0 % 64] !== 11'd2047 || wr_log[(w0 + 1) % 64] !== 11'd0) begin n_err++; $display("FAIL wrap_addr: got %0d,%0d required 2047,0", wr_log[w0 % 64], wr_log[(w0 + 1) % 64]); end
    n_checks++; if (mem[2047] !== fill(16'd2) || mem[0] !== fill(16'd11)) begin n_err++; $display("FAIL wrap_data: got %h/%h required %h/%h", mem[2047], mem[0], fill(16'd2), fill(16'd11)); end
  endtask

  task automatic test_len0;
    int dcyc;
    int w0;
    int r0;
    int p0;
    push(fill(16'd9));
    w0 = wr_cnt; r0 = rd_cnt; p0 = pop_cnt;
    launch(11'd0, 11'd100, 1'b1, 1'b0);
    wait_done(dcyc);
    $display("len0 run done_cyc=%0d", dcyc);
    n_checks++; if (dcyc !== 1) begin n_err++; $display("FAIL len0_latency: got %0d required 1", dcyc); end
    n_checks++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0 || pop_cnt - p0 !== 0) begin n_err++; $display("FAIL len0_access: got wr=%0d rd=%0d pop=%0d required 0", wr_cnt - w0, rd_cnt - r0, pop_cnt - p0); end
    wr_ptr = rd_ptr;
  endtask

  task automatic test_overflow(input logic r);
    int dcyc;
    logic [127:0] expv;
    mem[30] = fill(16'h7FFF);
    push(fill(16'd1));
    launch(11'd1, 11'd30, 1'b1, r);
    wait_done(dcyc);
    expv = r ? 128'd0 : fill(16'h8000);
    $display("overflow run relu=%0d sram30=%h", r, mem[30]);
    n_checks++; if (mem[30] !== expv) begin n_err++; $display("FAIL overflow relu=%0d: got %h required %h", r, mem[30], expv); end
    n_checks++; if (dcyc !== 3) begin n_err++; $display("FAIL overflow_latency relu=%0d: got %0d required 3", r, dcyc); end
  endtask

  task automatic test_reset_midrun;
    int w0;
    mem[40] = fill(16'd5);
    push(fill(16'd1));
    w0 = wr_cnt;
    launch(11'd1, 11'd40, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_checks++; if ({sram_cen, sram_wen} !== 2'b00) begin n_err++; $display("FAIL midrun_in_wr: got cen/wen=%b required 00", {sram_cen, sram_wen}); end
    reset = 1'b0;
    #1;
    n_checks++; if ({sram_cen, sram_wen, busy} !== 3'b110) begin n_err++; $display("FAIL midrun_release: got cen/wen/busy=%b required 110", {sram_cen, sram_wen, busy}); end
    @(negedge clk);
    reset = 1'b1;
    wr_ptr = rd_ptr;
    $display("midrun reset sram40=%h", mem[40]);
    n_checks++; if (mem[40] !== fill(16'd5) || wr_cnt - w0 !== 0) begin n_err++; $display("FAIL midrun_nowrite: got %h writes=%0d required %h writes=0", mem[40], wr_cnt - w0, fill(16'd5)); end
  endtask

  task automatic test_start_busy;
    int n_done;
    int w0;
    mem[50] = fill(16'd1);
    mem[60] = fill(16'hAAAA);
    push(fill(16'd2));
    w0 = wr_cnt;
    n_done = 0;
    launch(11'd1, 11'd50, 1'b1, 1'b0);
    @(negedge clk);
    len = 11'd0; base_addr = 11'd60; accum = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    $display("start-while-busy run dones=%0d sram50=%h", n_done, mem[50]);
    n_checks++; if (n_done !== 1) begin n_err++; $display("FAIL busy_start_dones: got %0d required 1", n_done); end
    n_checks++; if (mem[50] !== fill(16'd3) || wr_cnt - w0 !== 1) begin n_err++; $display("FAIL busy_start_data: got %h writes=%0d required %h writes=1", mem[50], wr_cnt - w0, fill(16'd3)); end
  endtask

  task automatic test_protocol;
    n_checks++; if (viol !== 0) begin n_err++; $display("FAIL protocol: got %0d violations required 0", viol); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b0; len = '0; base_addr = '0; accum = 1'b0; relu = 1'b0;
    sram_q = '0;
    test_reset();
    test_accum(1'b0);
    test_accum(1'b1);
    test_passthrough();
    test_stall();
    test_wrap();
    test_len0();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_reset_midrun();
    test_start_busy();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_wb_seq.md
PSUM_WB_SEQ -- requirements
Module: psum_wb_seq

Interface
REQ-001 SHALL have parameters, one per line:
  col, 8, number of columns per word
  psum_bw, 16, per-column partial-sum width (signed)
  addr_bw, 11, PSUM SRAM address width
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  start  in  1  one-cycle pulse; launches a writeback run
  len  in  addr_bw  number of words in the run, sampled on start
  base_addr  in  addr_bw  first SRAM address, sampled on start
  accum  in  1  1 = read-modify-write accumulate; 0 = passthrough, sampled on start
  relu  in  1  1 = clamp negative accumulated columns to 0, sampled on start
  busy  out  1  high while a run is active
  done  out  1  one-cycle pulse at run completion
  ofifo_valid  in  1  output FIFO non-empty
  ofifo_rd  out  1  pop strobe; ofifo_out is valid in the same cycle
  ofifo_out  in  col*psum_bw  FIFO head word
  sram_cen  out  1  SRAM chip enable, active-low
  sram_wen  out  1  SRAM write enable, active-low
  sram_a  out  addr_bw  SRAM address
  sram_d  out  col*psum_bw  SRAM write data
  sram_q  in  col*psum_bw  SRAM read data, valid one cycle after a read

Function
REQ-003 SHALL implement the states IDLE, RD, WR, PT and FIN.
REQ-004 SHALL, in IDLE, on start with len=0, go to FIN with no SRAM or FIFO access.
REQ-005 SHALL, in IDLE, on start with len>0, latch len, base_addr, accum and relu, clear the word counter, and go to RD when accum=1 or to PT when accum=0.
REQ-006 SHALL ignore start while busy=1.
REQ-007 SHALL, in RD with ofifo_valid=1, assert ofifo_rd, sram_cen=0 and sram_wen=1 with sram_a=current address, capture ofifo_out in a holding register, and go to WR.
REQ-008 SHALL, in RD with ofifo_valid=0, hold sram_cen=1 and ofifo_rd=0 and stay in RD (stall).
REQ-009 SHALL, in WR, drive sram_cen=0, sram_wen=0 and sram_a=the same address, with sram_d per column c = f(sram_q[c], hold[c]), then increment the counter.
REQ-010 SHALL, after WR, go to FIN if the counter reaches len, otherwise go to RD.
REQ-011 SHALL compute f as a signed psum_bw-bit sum truncated modulo 2^psum_bw; when relu=1, a column whose sum has its MSB set SHALL be written as 0.
REQ-012 SHALL, in PT with ofifo_valid=1, pop the FIFO and write ofifo_out unmodified (relu ignored) in the same cycle (cen=0, wen=0), giving 1 word per cycle.
REQ-013 SHALL, in PT with ofifo_valid=0, stall with no access, and go to FIN after len writes.
REQ-014 SHALL, in the accumulate path, take 2 cycles per word plus stall cycles.
REQ-015 SHALL compute the address as (base_addr + counter) mod 2^addr_bw, wrapping silently.
REQ-016 SHALL, in FIN, pulse done for one cycle and return to IDLE; busy SHALL be 1 in RD, WR, PT and FIN and 0 in IDLE.
REQ-017 SHALL never assert sram_wen=0 while sram_cen=1, and SHALL never assert ofifo_rd while ofifo_valid=0.

Reset
REQ-018 SHALL, on reset=0 (asynchronous, including mid-run), force state=IDLE, busy=0, done=0, ofifo_rd=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0, and clear the counter, holding register and latched config; any partially executed read-modify-write SHALL be abandoned without a write.

Structure
REQ-019 SHALL place the state encoding and the default parameter values in a shared package.
REQ-020 SHALL instantiate the existing per-column sfp unit col times as its sub-module for f, driving passthrough=0 with accum and relu from the latched config.

Verification
REQ-021 SHALL test accumulate: base=5, len=2, accum=1, relu=0, SRAM[5] all cols 3, FIFO words all cols 4 then all cols -7 with SRAM[6]=2 -> SRAM[5]=7 and SRAM[6]=-5 (0xFFFB); done 5 cycles after start.
REQ-022 SHALL test ReLU: same stimulus with relu=1 -> SRAM[6]=0, SRAM[5]=7.
REQ-023 SHALL test passthrough: accum=0, relu=1, len=3, FIFO holds 0x8001 in every column -> 3 consecutive write cycles, SRAM holds 0x8001 unmodified.
REQ-024 SHALL test stall: ofifo_valid low for 4 cycles during RD -> no cen/rd activity during the stall, result identical to the unstalled run.
REQ-025 SHALL test the boundaries: base=2047, len=2 -> writes to 2047 then 0; len=0 -> done the cycle after start with no access; overflow 0x7FFF+1 -> 0x8000 (0 with relu).
REQ-026 SHALL test reset and re-start: reset asserted during WR -> cen=wen=1 immediately with no write; start while busy -> ignored.
